// File: rtl/reg_trace_buf.sv
// Register-write trace buffer: captures watched register-file writes with a
// timestamp into a show-ahead FIFO. Supports drop-newest or overwrite-oldest
// when full, a saturating lost-entry counter and a synchronous flush.
module reg_trace_buf #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned TS_W       = 16,
  parameter logic [31:0] WATCH_MASK = 32'h0000_001E
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     wrap_mode,
  input  logic                     clear,
  input  logic                     wb_valid,
  input  logic [4:0]               wb_addr,
  input  logic [XLEN-1:0]          wb_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [4:0]               out_addr,
  output logic [XLEN-1:0]          out_data,
  output logic [TS_W-1:0]          out_time,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [4:0]      addr;
    logic [XLEN-1:0] data;
    logic [TS_W-1:0] ts;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wptr, rptr, wptr_n, rptr_n;
  logic [CW-1:0]   count_n;
  logic [15:0]     drop_n;
  logic [TS_W-1:0] ts;
  logic            cap_c, full_c, pop_c, wr_c;
  entry_t          new_c, head_n;

  // Next-state computation for pointers, occupancy, drop counter and head entry
  always_comb begin
    cap_c   = en && wb_valid && (wb_addr != 5'd0) && WATCH_MASK[wb_addr];
    full_c  = (count == CW'(DEPTH));
    pop_c   = out_valid && out_ready;
    new_c   = '{addr: wb_addr, data: wb_data, ts: ts};
    wr_c    = 1'b0;
    wptr_n  = wptr;
    rptr_n  = rptr;
    count_n = count;
    drop_n  = drop_cnt;
    head_n  = '0;
    if (clear) begin
      wptr_n  = '0;
      rptr_n  = '0;
      count_n = '0;
      drop_n  = '0;
    end else begin
      if (pop_c) rptr_n = rptr + AW'(1);
      if (cap_c) begin
        if (!full_c || pop_c) begin
          wr_c   = 1'b1;
          wptr_n = wptr + AW'(1);
          if (!pop_c) count_n = count + CW'(1);
        end else begin
          // Full with no pop: either overwrite the oldest entry or discard the new one
          if (wrap_mode) begin
            wr_c   = 1'b1;
            wptr_n = wptr + AW'(1);
            rptr_n = rptr + AW'(1);
          end
          if (drop_cnt != 16'hFFFF) drop_n = drop_cnt + 16'd1;
        end
      end else if (pop_c) begin
        count_n = count - CW'(1);
      end
    end
    // The new head may be the entry being written this cycle (bypass the array)
    if (count_n != '0) head_n = (wr_c && (rptr_n == wptr)) ? new_c : mem[rptr_n];
  end

  // Entry storage; needs no reset since the head registers gate visibility
  always_ff @(posedge clk) begin
    if (wr_c) mem[wptr] <= new_c;
  end

  // Control state, timestamp and registered head outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts        <= '0;
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      drop_cnt  <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      out_time  <= '0;
    end else begin
      ts        <= ts + TS_W'(1);
      wptr      <= wptr_n;
      rptr      <= rptr_n;
      count     <= count_n;
      drop_cnt  <= drop_n;
      out_valid <= (count_n != '0);
      out_addr  <= head_n.addr;
      out_data  <= head_n.data;
      out_time  <= head_n.ts;
    end
  end

endmodule

// File: tb/tb_reg_trace_buf.sv
// Randomized bench for reg_trace_buf with a queue-based reference model.
module tb_reg_trace_buf;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned TS_W  = 16;
  localparam logic [31:0] MASK  = 32'h0000_001E;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en = 1'b1, wrap_mode = 1'b0, clear = 1'b0;
  logic            wb_valid = 1'b0;
  logic [4:0]      wb_addr = '0;
  logic [XLEN-1:0] wb_data = '0;
  logic            out_ready = 1'b0;
  logic            out_valid;
  logic [4:0]      out_addr;
  logic [XLEN-1:0] out_data;
  logic [TS_W-1:0] out_time;
  logic [4:0]      count;
  logic [15:0]     drop_cnt;

  int checks = 0;
  int failures = 0;

  reg_trace_buf #(.XLEN(XLEN), .DEPTH(DEPTH), .TS_W(TS_W), .WATCH_MASK(MASK)) dut (
    .clk(clk), .rst(rst), .en(en), .wrap_mode(wrap_mode), .clear(clear),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .out_time(out_time), .count(count), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]      a;
    logic [XLEN-1:0] d;
    logic [TS_W-1:0] t;
  } ent_t;

  ent_t            q[$];
  logic [TS_W-1:0] m_ts = '0;
  int              m_drop = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain queue semantics evaluated at each rising edge
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_ts   = '0;
      m_drop = 0;
    end else begin
      bit   cap, pop;
      ent_t e;
      cap = en && wb_valid && (wb_addr != 0) && MASK[wb_addr];
      e   = '{a: wb_addr, d: wb_data, t: m_ts};
      if (clear) begin
        q.delete();
        m_drop = 0;
      end else begin
        pop = (q.size() != 0) && out_ready;
        if (pop) void'(q.pop_front());
        if (cap) begin
          if (q.size() < DEPTH) q.push_back(e);
          else begin
            if (wrap_mode) begin
              void'(q.pop_front());
              q.push_back(e);
            end
            if (m_drop < 65535) m_drop++;
          end
        end
      end
      m_ts = m_ts + 1'b1;
    end
  end

  // Compare DUT against the model every cycle, away from the active edge
  always @(negedge clk) begin
    chk("count", 64'(count), 64'(q.size()));
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    if (q.size() != 0) begin
      chk("out_addr", 64'(out_addr), 64'(q[0].a));
      chk("out_data", 64'(out_data), 64'(q[0].d));
      chk("out_time", 64'(out_time), 64'(q[0].t));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [XLEN-1:0] d);
    wb_valid = 1'b1;
    wb_addr  = a;
    wb_data  = d;
    tick();
    wb_valid = 1'b0;
  endtask

  initial begin
    int ready_pct;
    tick(); tick();
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_valid", 64'(out_valid), 64'd0);
    rst = 1'b0;

    // Single capture into empty FIFO
    wr(5'd1, 32'h5);
    chk("first_valid", 64'(out_valid), 64'd1);
    chk("first_addr", 64'(out_addr), 64'd1);
    chk("first_data", 64'(out_data), 64'd5);
    chk("first_count", 64'(count), 64'd1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Non-captured writes
    wr(5'd0, 32'hAA);
    wr(5'd5, 32'hBB);
    en = 1'b0; wr(5'd2, 32'hCC); en = 1'b1;
    chk("nocap_count", 64'(count), 64'd0);
    chk("nocap_drop", 64'(drop_cnt), 64'd0);

    // Overflow, drop newest
    wrap_mode = 1'b0;
    for (int i = 0; i < 20; i++) wr(5'd3, 32'(i));
    chk("drop_count", 64'(count), 64'd16);
    chk("drop_head", 64'(out_data), 64'd0);
    chk("drop_drop", 64'(drop_cnt), 64'd4);

    // Overflow, overwrite oldest
    clear = 1'b1; tick(); clear = 1'b0;
    wrap_mode = 1'b1;
    for (int i = 0; i < 20; i++) wr(5'd3, 32'(i));
    chk("wrap_count", 64'(count), 64'd16);
    chk("wrap_head", 64'(out_data), 64'd4);
    chk("wrap_tail_model", 64'(q[$].d), 64'd19);
    chk("wrap_drop", 64'(drop_cnt), 64'd4);

    // Full, simultaneous push and pop
    out_ready = 1'b1; wr(5'd3, 32'd100); out_ready = 1'b0;
    chk("pp_count", 64'(count), 64'd16);
    chk("pp_drop", 64'(drop_cnt), 64'd4);
    chk("pp_head", 64'(out_data), 64'd5);

    // Drain to 8 entries, then asynchronous reset mid-operation
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    out_ready = 1'b0;
    chk("pre_rst_count", 64'(count), 64'd8);
    rst = 1'b1; #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_time", 64'(out_time), 64'd0);
    tick(); rst = 1'b0;

    // Clear beats a same-cycle capture
    for (int i = 0; i < 8; i++) wr(5'd4, 32'(i + 50));
    clear = 1'b1; wr(5'd3, 32'h77); clear = 1'b0;
    chk("clr_count", 64'(count), 64'd0);
    chk("clr_valid", 64'(out_valid), 64'd0);
    chk("clr_drop", 64'(drop_cnt), 64'd0);

    // Randomized traffic
    ready_pct = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) ready_pct = $urandom_range(0, 100);
      en        = ($urandom_range(0, 7) != 0);
      wrap_mode = $urandom_range(0, 1) == 1;
      clear     = ($urandom_range(0, 63) == 0);
      wb_valid  = ($urandom_range(0, 9) < 7);
      wb_addr   = 5'($urandom_range(0, 7));
      wb_data   = $urandom;
      out_ready = ($urandom_range(0, 99) < ready_pct);
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1; #1;
        chk("rnd_rst_count", 64'(count), 64'd0);
        tick(); rst = 1'b0;
      end else begin
        tick();
      end
    end
    clear = 1'b0; wb_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_trace_buf.md
REG_TRACE_BUF -- requirements
Module: reg_trace_buf

Interface
REQ-001 Parameter XLEN, default 32, width of captured register-write data.
REQ-002 Parameter DEPTH, default 16, trace FIFO entries; SHALL be a power of two, at least 2.
REQ-003 Parameter TS_W, default 16, timestamp width.
REQ-004 Parameter WATCH_MASK, default 32'h0000_001E (x1..x4), bit i set enables capture of register xi.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 en  input  1  capture enable.
REQ-008 wrap_mode  input  1  0 = drop newest when full, 1 = overwrite oldest when full.
REQ-009 clear  input  1  synchronous flush.
REQ-010 wb_valid  input  1  CPU register-file write strobe.
REQ-011 wb_addr  input  5  destination register index.
REQ-012 wb_data  input  XLEN  write data.
REQ-013 out_valid  output  1  head entry available.
REQ-014 out_ready  input  1  consumer accepts head entry.
REQ-015 out_addr  output  5  head entry register index.
REQ-016 out_data  output  XLEN  head entry data.
REQ-017 out_time  output  TS_W  head entry timestamp.
REQ-018 count  output  $clog2(DEPTH)+1  entries held.
REQ-019 drop_cnt  output  16  lost-entry counter.

Function
REQ-020 Free-running timestamp counter SHALL increment every cycle, wrap from all-ones to 0, and is not affected by clear.
REQ-021 Capture condition: en && wb_valid && wb_addr != 0 && WATCH_MASK[wb_addr]; writes to x0 are never captured.
REQ-022 A captured entry SHALL hold {wb_addr, wb_data, timestamp value in the capture cycle}.
REQ-023 Latency: an entry captured into an empty FIFO at edge N SHALL appear at the outputs with out_valid=1 after edge N.
REQ-024 FIFO is show-ahead: out_valid = (count != 0); out_addr, out_data and out_time reflect the oldest entry.
REQ-025 Pop occurs when out_valid && out_ready; out_ready while empty SHALL have no effect.
REQ-026 While out_valid && !out_ready, outputs SHALL stay stable, except in the wrap_mode=1 overwrite case of REQ-029.
REQ-027 Push and pop in the same cycle SHALL both occur with count unchanged, including when full.
REQ-028 Full, wrap_mode=0, push without pop: the new entry is discarded, drop_cnt increments, and the FIFO is unchanged.
REQ-029 Full, wrap_mode=1, push without pop: the oldest entry is discarded, the new entry is stored, count stays DEPTH, drop_cnt increments, and the head advances.
REQ-030 drop_cnt SHALL saturate at 16'hFFFF.
REQ-031 Read and write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH.
REQ-032 clear SHALL empty the FIFO and zero drop_cnt at the next edge; it has priority over a same-cycle push or pop, and that cycle's capture is lost and not counted.
REQ-033 wrap_mode and en MAY change on any cycle and take effect in the same cycle.

Reset
REQ-034 rst=1 SHALL immediately force count=0, out_valid=0, drop_cnt=0, pointers=0, timestamp=0, out_addr=0, out_data=0 and out_time=0, including mid-operation.
REQ-035 After rst deasserts, the first capture SHALL be possible at the first rising edge.

Verification
REQ-036 Reset then one write wb_addr=1, wb_data=32'h5 -> next cycle out_valid=1, out_addr=1, out_data=5, count=1.
REQ-037 Writes to x0, x5 (mask bit clear) and x2 with en=0 -> count stays 0, drop_cnt=0.
REQ-038 out_ready=0, wrap_mode=0, 20 captures of x3 with data 0..19 (DEPTH=16) -> count=16, head data=0, drop_cnt=4.
REQ-039 Same as REQ-038 with wrap_mode=1 -> count=16, head data=4, tail data=19, drop_cnt=4.
REQ-040 FIFO full, capture and pop in the same cycle -> count=16, no drop, head advances by one.
REQ-041 Assert rst while 8 entries are held and clear with a same-cycle capture -> count=0, out_valid=0, drop_cnt=0 immediately on rst; clear discards the capture.
